// File: rtl/vga_vblank_mem_scheduler.sv
// rtl/vga_vblank_mem_scheduler.sv - parameter RAM arbiter: render reads always win, buffered writes drain only in vblank
module vga_vblank_mem_scheduler #(
  parameter int AW         = 4,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int V_ACTIVE   = 480,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int LW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    hpos,
  input  logic [9:0]    vpos,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [LW-1:0] fifo_level,
  output logic [7:0]    frame_cnt,
  output logic          frame_tick
);

  typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} grant_t;

  grant_t        grant;
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic          vblank;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          vblank_start;

  assign vblank       = (vpos >= 10'(V_ACTIVE));
  assign vblank_start = (vpos == 10'(V_ACTIVE)) && (hpos == 10'd0);
  assign fifo_empty   = (fifo_level == '0);
  assign wr_ready     = (fifo_level != LW'(FIFO_DEPTH));
  assign push         = wr_valid && wr_ready;
  assign pop          = (grant == GRANT_WR);
  assign rd_data      = mem_rdata;

  always_comb begin
    grant = IDLE;
    if (!rst) begin
      if (rd_req)
        grant = GRANT_RD;
      else if (vblank && !fifo_empty)
        grant = GRANT_WR;
    end
  end

  // Address/data hold their last driven values while the port is idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = last_addr;
    mem_wdata = last_wdata;
    case (grant)
      GRANT_RD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      GRANT_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rd_ptr];
        mem_wdata = fifo_data[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
      rd_valid   <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (mem_en)
        last_addr <= mem_addr;
      if (mem_we)
        last_wdata <= mem_wdata;
      rd_valid   <= rd_req;
      frame_tick <= vblank_start;
      if (vblank_start)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_vblank_mem_scheduler.sv
// tb/tb_vga_vblank_mem_scheduler.sv - directed and randomized checks against a queue-based model
module tb_vga_vblank_mem_scheduler;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int VA = 480;
  localparam int H_TOTAL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    hpos = '0;
  logic [9:0]    vpos = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    fifo_level;
  logic [7:0]    frame_cnt;
  logic          frame_tick;

  vga_vblank_mem_scheduler #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level), .frame_cnt(frame_cnt), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Environment RAM: one-cycle read latency, driven by the DUT's port.
  logic [DW-1:0] env_ram [16];
  logic          ram_pend = 1'b0;
  logic [DW-1:0] ram_q = '0;

  always @(negedge clk) begin
    ram_pend = mem_en && !mem_we;
    if (ram_pend) ram_q = env_ram[mem_addr];
    if (mem_en && mem_we) env_ram[mem_addr] = mem_wdata;
  end

  always @(posedge clk) begin
    #1;
    if (ram_pend) mem_rdata = ram_q;
  end

  // Reference model: pending writes as a queue, its own RAM image, frame bookkeeping.
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  ent_t          q[$];
  logic [DW-1:0] mram [16];
  logic          m_rv = 1'b0;
  logic [DW-1:0] m_rd = '0;
  logic [7:0]    m_cnt = '0;
  logic          m_tick = 1'b0;
  logic [AW-1:0] m_laddr = '0;
  logic [DW-1:0] m_lwd = '0;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  int            sz;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_rv = 1'b0; m_cnt = '0; m_tick = 1'b0; m_laddr = '0; m_lwd = '0;
    end
    sz = q.size();
    e_en = 1'b0; e_we = 1'b0; e_addr = m_laddr; e_wd = m_lwd;
    if (!rst && rd_req) begin
      e_en = 1'b1; e_addr = rd_addr;
    end else if (!rst && vpos >= VA && sz > 0) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = q[0].a; e_wd = q[0].d;
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("wr_ready", wr_ready, sz < DEPTH);
    chk("fifo_level", fifo_level, sz);
    chk("rd_valid", rd_valid, m_rv);
    if (m_rv) chk("rd_data", rd_data, m_rd);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("frame_tick", frame_tick, m_tick);
    if (!rst) begin
      if (rd_req) m_rd = mram[rd_addr];
      m_rv = rd_req;
      if (e_we) begin
        mram[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (wr_valid && sz < DEPTH) q.push_back({wr_addr, wr_data});
      if (e_en) m_laddr = e_addr;
      if (e_we) m_lwd = e_wd;
      m_tick = (vpos == VA && hpos == 0);
      if (m_tick) m_cnt = m_cnt + 8'd1;
    end
  end

  // Stimulus: compressed timing generator plus optional random traffic.
  logic       freeze = 1'b1;
  logic       rand_mode = 1'b0;
  logic [9:0] v_lo = 10'd0;
  logic [9:0] v_hi = 10'd499;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!freeze) begin
      if (hpos == H_TOTAL - 1) begin
        hpos = 10'd0;
        vpos = (vpos == v_hi) ? v_lo : vpos + 10'd1;
      end else begin
        hpos = hpos + 10'd1;
      end
    end
    if (rand_mode) begin
      rd_req   = ($urandom_range(0, 2) == 0);
      rd_addr  = AW'($urandom);
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
    end
  endtask

  int            we_act, wcnt, rp_we, rv_cnt, ticks, bad_pos, stale;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wd;

  initial begin
    for (int i = 0; i < 16; i++) begin
      env_ram[i] = DW'($urandom);
      mram[i] = env_ram[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_level", fifo_level, 0);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_rd_valid", rd_valid, 0);
    cyc();
    rst = 1'b0;

    // Write pushed in active video waits for vblank.
    freeze = 1'b0; vpos = 10'd100; hpos = 10'd0;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    cyc();
    wr_valid = 1'b0;
    we_act = 0;
    for (int i = 0; i < 2000 && !(vpos == 10'd480 && hpos == 10'd0); i++) begin
      @(negedge clk);
      if (mem_we) we_act++;
      cyc();
    end
    chk("active_no_write", we_act, 0);
    chk("reached_vblank", vpos, 480);
    wcnt = 0; waddr = '0; wd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_we) begin wcnt++; waddr = mem_addr; wd = mem_wdata; end
      cyc();
    end
    chk("vblank_write_count", wcnt, 1);
    chk("vblank_write_addr", waddr, 4'd3);
    chk("vblank_write_data", wd, 8'hA5);
    @(negedge clk);
    chk("vblank_level", fifo_level, 0);

    // Reset mid-frame with three entries queued.
    freeze = 1'b1; vpos = 10'd200; hpos = 10'd5;
    cyc();
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_addr = AW'(8 + k); wr_data = DW'($urandom);
      cyc();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("queued_three", fifo_level, 3);
    cyc();
    rst = 1'b1; rd_req = 1'b1;
    #1;
    chk("midrst_level", fifo_level, 0);
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    cyc();
    rst = 1'b0; rd_req = 1'b0; vpos = 10'd490;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we) stale++;
      cyc();
    end
    chk("no_stale_write", stale, 0);

    // Reads hold off writes in vblank; writes then drain in order.
    rp_we = 0; rv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rd_req = 1'b1; rd_addr = AW'(i);
      wr_valid = (i < 2); wr_addr = AW'(10 + i); wr_data = DW'(8'h50 + i);
      @(negedge clk);
      if (mem_we) rp_we++;
      if (i > 0 && rd_valid) rv_cnt++;
      cyc();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    if (rd_valid) rv_cnt++;
    chk("prio_rd_valid_count", rv_cnt, 5);
    chk("prio_no_write", rp_we, 0);
    chk("drain0_we", mem_we, 1);
    chk("drain0_addr", mem_addr, 4'd10);
    chk("drain0_data", mem_wdata, 8'h50);
    cyc();
    @(negedge clk);
    chk("drain1_we", mem_we, 1);
    chk("drain1_addr", mem_addr, 4'd11);
    chk("drain1_data", mem_wdata, 8'h51);
    cyc();
    @(negedge clk);
    chk("drain_done", fifo_level, 0);

    // Full FIFO refuses a fifth entry; one pop reopens it.
    vpos = 10'd200;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_addr = AW'(k); wr_data = DW'($urandom);
      cyc();
    end
    wr_addr = 4'd15;
    @(negedge clk);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_level", fifo_level, 4);
    cyc();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("fifth_rejected", fifo_level, 4);
    cyc();
    vpos = 10'd480;
    @(negedge clk);
    chk("full_pop_we", mem_we, 1);
    cyc();
    vpos = 10'd200;
    @(negedge clk);
    chk("after_pop_ready", wr_ready, 1);
    chk("after_pop_level", fifo_level, 3);
    cyc();
    vpos = 10'd490;
    repeat (4) cyc();

    // Read latency and data.
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    cyc();
    wr_valid = 1'b0;
    cyc();
    rd_req = 1'b1; rd_addr = 4'd7;
    cyc();
    rd_req = 1'b0;
    @(negedge clk);
    chk("lat_rd_valid", rd_valid, 1);
    chk("lat_rd_data", rd_data, 8'h3C);

    // 257 compressed frames with random traffic.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    freeze = 1'b0; v_lo = 10'd470; v_hi = 10'd499; vpos = 10'd470; hpos = 10'd0;
    rand_mode = 1'b1;
    ticks = 0; bad_pos = 0;
    for (int c = 0; c < 257 * 120; c++) begin
      @(negedge clk);
      if (frame_tick) begin
        ticks++;
        if (!(vpos == 10'd480 && hpos == 10'd1)) bad_pos++;
      end
      cyc();
    end
    rand_mode = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("frame_tick_count", ticks, 257);
    chk("frame_tick_position", bad_pos, 0);
    chk("frame_cnt_wrap", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_vblank_mem_scheduler.md
Name: vga_vblank_mem_scheduler

Overview:
- Shares one single-port synchronous parameter RAM between two users.
  - The render pixel pipeline reads from it.
  - A host/animation writer updates it.
- Reads have absolute priority at all times.
- Buffered writes are committed only during vertical blanking and only in cycles with no read, so the active picture never tears.
- Sits between the VGA timing generator (hpos/vpos) and the parameter RAM; also emits the frame counter and frame tick used by animation logic.

Parameters:
- AW, 4, RAM address width.
- DW, 8, RAM data width.
- FIFO_DEPTH, 4, write buffer entries (power of two, >=2).
- V_ACTIVE, 480, first vblank line (vpos >= V_ACTIVE is vblank).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- hpos  in  10  current horizontal pixel from the timing generator.
- vpos  in  10  current line from the timing generator.
- rd_req  in  1  render read request for this cycle.
- rd_addr  in  AW  render read address.
- rd_valid  out  1  rd_data valid (one cycle after the granted request).
- rd_data  out  DW  read data (passthrough of mem_rdata).
- wr_valid  in  1  writer offers an entry.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_ready  out  1  FIFO can accept; equals !full.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with !mem_we.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held.
- frame_cnt  out  8  frames since reset, wraps.
- frame_tick  out  1  one-cycle pulse at vblank start.

Behaviour:
- Reset values:
  - fifo_level, frame_cnt, frame_tick, rd_valid, mem_en, mem_we = 0.
  - mem_addr, mem_wdata = 0.
  - wr_ready = 1.
  - Reset asserted mid-operation flushes the FIFO; in-flight rd_valid is dropped.
- Write FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready depends only on registered level; it does not look at same-cycle pop.
  - When full, wr_ready = 0, even if a pop occurs that cycle.
  - Simultaneous push and pop leaves the level unchanged; order is preserved.
- Port arbitration is combinational on mem_* and evaluated every cycle:
  - GRANT_RD: rd_req=1. Drive mem_en=1, mem_we=0, mem_addr=rd_addr. Next cycle rd_valid=1 and rd_data=mem_rdata.
  - GRANT_WR: rd_req=0, vblank=1, fifo not empty. Drive mem_en=1, mem_we=1, head addr/data; pop the head.
  - IDLE: otherwise. mem_en=0, mem_we=0, mem_addr/mem_wdata hold last values.
- Never write outside vblank, regardless of FIFO state.
- A read to an address with a pending FIFO write returns the old RAM contents; there is no forwarding.
- rd_valid is a registered copy of rd_req; latency is exactly 1 cycle and back-to-back reads are allowed every cycle.
- frame_tick:
  - Registered pulse, high in the cycle after vpos==V_ACTIVE && hpos==0 is sampled.
  - Exactly once per frame.
- frame_cnt increments together with frame_tick; 255 wraps to 0.
- Entries left in the FIFO when vblank ends remain buffered until the next vblank.

Test Plan:
- Reset check: assert rst mid-frame with 3 entries queued.
  - Required: fifo_level=0, wr_ready=1, mem_en=0, frame_cnt=0 immediately; after release, no stale write appears.
- Active-video blocking: push {addr 3, data 0xA5} at vpos=100 with rd_req=0.
  - Required: mem_we stays 0 through vpos=479.
  - Required: at vpos=480, exactly one write (addr 3, 0xA5) occurs and fifo_level goes to 0.
- Read priority in vblank: queue 2 writes, hold rd_req=1 for 5 cycles at vpos=490.
  - Required: 5 reads, rd_valid high each following cycle, no writes.
  - Required: both writes drain in the 2 cycles after rd_req drops, in push order.
- Full FIFO: push 4 entries during active video.
  - Required: wr_ready=0 and fifo_level=4; a 5th wr_valid is not accepted.
  - Required: after one vblank pop, wr_ready=1 the following cycle.
- Read latency/data: model RAM holding 0x3C at addr 7; rd_req with rd_addr=7.
  - Required: rd_valid=1 and rd_data=0x3C exactly 1 cycle later.
- Frame counter: run 257 frames.
  - Required: 257 frame_tick pulses, each one cycle wide, at the hpos=0/vpos=480 boundary.
  - Required: frame_cnt ends at 1.
